data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/mem_resp_pkg.sv | 14 +
 rtl/data_mem_array.sv | 25 ++
 rtl/data_mem_responder.sv | 158 +++++++++++++++
 tb/tb_data_mem_responder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and defaults for the latency-configurable data memory responder.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0400_4000;
  localparam int          DEFAULT_LATENCY   = 2;
  localparam int          CNT_W             = 4;

endpackage

// File: rtl/data_mem_array.sv
// Word-addressed storage: synchronous write, combinational read, no reset on contents.
module data_mem_array #(
  parameter int NBits        = 32,
  parameter int MEMORY_DEPTH = 512,
  parameter int AW           = 9
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [NBits-1:0] wdata,
  output logic [NBits-1:0] rdata
);

  logic [NBits-1:0] mem [MEMORY_DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding memory responder: accepts one request, waits LATENCY cycles,
// executes the access and holds the response until the initiator takes it.
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int               NBits        = 32,
  parameter int               MEMORY_DEPTH = 512,
  parameter int               LATENCY      = DEFAULT_LATENCY,
  parameter logic [NBits-1:0] BASE_ADDR    = NBits'(DEFAULT_BASE_ADDR)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [NBits-1:0] req_addr,
  input  logic [NBits-1:0] req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [NBits-1:0] resp_rdata,
  output logic             resp_err
);

  localparam int               AW       = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam logic [NBits-1:0] DEPTH_W  = NBits'(MEMORY_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q, write_d;
  logic [NBits-1:0] addr_q, addr_d;
  logic [NBits-1:0] wdata_q, wdata_d;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic [NBits-1:0] resp_rdata_q, resp_rdata_d;
  logic             resp_err_q, resp_err_d;

  logic [NBits-1:0] offset_s;
  logic [NBits-1:0] word_idx_s;
  logic [NBits-1:0] mem_rdata_s;
  logic [AW-1:0]    mem_addr_s;
  logic             addr_err_s;
  logic             accept_s;
  logic             exec_s;
  logic             mem_we_s;

  assign accept_s = req_valid && req_ready_q;

  // Address decode; addresses below BASE_ADDR wrap to huge offsets and fail the range test
  always_comb begin
    offset_s   = addr_q - BASE_ADDR;
    word_idx_s = offset_s >> 2;
    addr_err_s = (addr_q[1:0] != 2'b00) || (word_idx_s >= DEPTH_W);
    mem_addr_s = word_idx_s[AW-1:0];
  end

  data_mem_array #(
    .NBits       (NBits),
    .MEMORY_DEPTH(MEMORY_DEPTH),
    .AW          (AW)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we_s),
    .addr (mem_addr_s),
    .wdata(wdata_q),
    .rdata(mem_rdata_s)
  );

  // Next-state and response generation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    exec_s       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_LOAD;
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          exec_s       = 1'b1;
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = addr_err_s;
          resp_rdata_d = (addr_err_s || write_q) ? {NBits{1'b0}} : mem_rdata_s;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          resp_rdata_d = {NBits{1'b0}};
          resp_err_d   = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        cnt_d        = {CNT_W{1'b0}};
        resp_valid_d = 1'b0;
        resp_rdata_d = {NBits{1'b0}};
        resp_err_d   = 1'b0;
      end
    endcase

    // Ready only while idle, so no accept can coincide with a response completing
    req_ready_d = (state_d == ST_IDLE);
    mem_we_s    = exec_s && write_q && !addr_err_s;
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      write_q      <= 1'b0;
      addr_q       <= {NBits{1'b0}};
      wdata_q      <= {NBits{1'b0}};
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= {NBits{1'b0}};
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: LATENCY=2 instance for the main function, LATENCY=3 instance for reset abort.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst3;
  logic        sel;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_ready;

  logic        rr2, rv2, re2, rr3, rv3, re3;
  logic [31:0] rd2, rd3;
  logic        rr, rv, re;
  logic [31:0] rd;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rr = sel ? rr3 : rr2;
  assign rv = sel ? rv3 : rv2;
  assign rd = sel ? rd3 : rd2;
  assign re = sel ? re3 : re2;

  data_mem_responder #(.NBits(32), .MEMORY_DEPTH(512), .LATENCY(2), .BASE_ADDR(32'h0400_4000)) u_dut (
    .clk(clk), .reset(rst), .req_valid(req_valid & ~sel), .req_ready(rr2),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv2), .resp_ready(resp_ready & ~sel), .resp_rdata(rd2), .resp_err(re2)
  );

  data_mem_responder #(.NBits(32), .MEMORY_DEPTH(512), .LATENCY(3), .BASE_ADDR(32'h0400_4000)) u_dut3 (
    .clk(clk), .reset(rst | rst3), .req_valid(req_valid & sel), .req_ready(rr3),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv3), .resp_ready(resp_ready & sel), .resp_rdata(rd3), .resp_err(re3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Present a request and return the cycle of the accepting edge
  task automatic wait_accept(input string tag, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, output int acc_cyc);
    logic ok = 1'b0;
    acc_cyc = 0;
    req_write = wr; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (rr) begin
        @(posedge clk); #1;
        acc_cyc = cyc;
        ok = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    req_valid = 1'b0;
    check({tag, " accept"}, ok, 1'b1);
  endtask

  task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err, input logic hold);
    int   acc_cyc;
    int   rsp_cyc = 0;
    int   exp_lat;
    logic ok = 1'b0;
    exp_lat = sel ? 3 : 2;
    wait_accept(tag, wr, addr, wd, acc_cyc);
    for (int k = 0; k < 20 && !ok; k++) begin
      if (rv) begin
        ok = 1'b1;
        rsp_cyc = cyc;
      end else begin
        @(posedge clk); #1;
      end
    end
    check({tag, " resp_valid"}, ok, 1'b1);
    check({tag, " latency"}, rsp_cyc - acc_cyc, exp_lat);
    check({tag, " rdata"}, rd, exp_rd);
    check({tag, " err"}, re, exp_err);
    if (!hold) begin
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check({tag, " resp_clr"}, rv, 1'b0);
    end
  endtask

  int acc[8];
  int n_acc;
  int dummy;
  int seen_rv;
  logic rdy;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rst3 = 1'b0; sel = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst req_ready", rr, 1'b1);
    check("rst resp_valid", rv, 1'b0);
    check("rst resp_rdata", rd, 32'h0);
    check("rst resp_err", re, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic write then read
    do_req("wr_4008", 1'b1, 32'h0400_4008, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
    do_req("rd_4008", 1'b0, 32'h0400_4008, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // Misaligned accesses; 0x..400A decodes to the same word as 0x..4008
    do_req("rd_mis", 1'b0, 32'h0400_4002, 32'h0, 32'h0, 1'b1, 1'b0);
    do_req("wr_mis", 1'b1, 32'h0400_400A, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    do_req("rd_4008b", 1'b0, 32'h0400_4008, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // Out of range: index 512 aliases word 0, below-base aliases word 511 if unguarded
    do_req("wr_idx0", 1'b1, 32'h0400_4000, 32'h0000_1357, 32'h0, 1'b0, 1'b0);
    do_req("wr_idx511", 1'b1, 32'h0400_47FC, 32'hA5A5_5A5A, 32'h0, 1'b0, 1'b0);
    do_req("wr_idx512", 1'b1, 32'h0400_4800, 32'h1111_1111, 32'h0, 1'b1, 1'b0);
    do_req("wr_below", 1'b1, 32'h0400_3FFC, 32'h2222_2222, 32'h0, 1'b1, 1'b0);
    do_req("rd_idx511", 1'b0, 32'h0400_47FC, 32'h0, 32'hA5A5_5A5A, 1'b0, 1'b0);
    do_req("rd_idx0", 1'b0, 32'h0400_4000, 32'h0, 32'h0000_1357, 1'b0, 1'b0);

    // Back-pressure: response held, competing request ignored
    do_req("wr_4010", 1'b1, 32'h0400_4010, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
    do_req("rd_hold", 1'b0, 32'h0400_4008, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    req_write = 1'b1; req_addr = 32'h0400_4010; req_wdata = 32'hFFFF_FFFF; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("hold resp_valid", rv, 1'b1);
      check("hold rdata", rd, 32'hDEAD_BEEF);
      check("hold err", re, 1'b0);
      check("hold req_ready", rr, 1'b0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("hold release", rv, 1'b0);
    do_req("rd_4010", 1'b0, 32'h0400_4010, 32'h0, 32'h1234_5678, 1'b0, 1'b0);

    // Back-to-back reads: accepts every LATENCY+2 cycles
    req_write = 1'b0; req_addr = 32'h0400_4008; req_valid = 1'b1; resp_ready = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 24; i++) begin
      rdy = rr;
      @(posedge clk); #1;
      if (rdy && n_acc < 8) begin
        acc[n_acc] = cyc;
        n_acc++;
      end
    end
    req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("b2b accepts", n_acc >= 5, 1'b1);
    for (int i = 1; i < n_acc; i++) check("b2b spacing", acc[i] - acc[i-1], 4);

    // LATENCY=3 instance: reset one cycle after a write accept aborts it
    sel = 1'b1;
    @(posedge clk); #1;
    do_req("l3_wr", 1'b1, 32'h0400_4020, 32'h0BAD_F00D, 32'h0, 1'b0, 1'b0);
    wait_accept("l3_abort", 1'b1, 32'h0400_4020, 32'hCAFE_0001, dummy);
    @(posedge clk); #1;
    rst3 = 1'b1;
    @(posedge clk); #1;
    check("abort req_ready", rr, 1'b1);
    rst3 = 1'b0;
    seen_rv = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rv) seen_rv++;
    end
    check("abort no_resp", seen_rv, 0);
    do_req("l3_rd", 1'b0, 32'h0400_4020, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
